// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter slice.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MAX_CYCLES = 40;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    logic [IW-1:0] idx [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_rot
        logic [IW:0] sum;
        assign sum    = {1'b0, rr_ptr} + (IW+1)'(k);
        assign idx[k] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                : sum[IW-1:0];
    end

    // Scan farthest-first so the closest hit to rr_ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[idx[k]]) begin
                gnt_idx = idx[k];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among N_REQ clients,
// with a watchdog that aborts the multiplier and returns a timeout response.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         ack,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_overflow,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     m_start,
    output logic [WIDTH-1:0]         m_multiplicand,
    output logic [WIDTH-1:0]         m_multiplier,
    output logic                     m_abort,
    input  logic                     m_done,
    input  logic [2*WIDTH-1:0]       m_result,
    input  logic                     m_overflow
);

    localparam int IW = idx_w(N_REQ);
    localparam int WW = idx_w(MAX_CYCLES + 1);

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant;
    logic [WW-1:0]  watchdog;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_vld;
    logic           expired;

    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign busy    = (state != IDLE);
    assign expired = (watchdog == WW'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            watchdog       <= '0;
            m_start        <= 1'b0;
            m_abort        <= 1'b0;
            m_multiplicand <= '0;
            m_multiplier   <= '0;
            ack            <= '0;
            rsp_result     <= '0;
            rsp_overflow   <= 1'b0;
            rsp_timeout    <= 1'b0;
        end else begin
            m_start <= 1'b0;
            m_abort <= 1'b0;
            ack     <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        grant          <= gnt_idx;
                        m_multiplicand <= a_arr[gnt_idx];
                        m_multiplier   <= b_arr[gnt_idx];
                        m_start        <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + WW'(1);
                    // A completion in the expiry cycle still counts as a result.
                    if (m_done) begin
                        rsp_result   <= m_result;
                        rsp_overflow <= m_overflow;
                        rsp_timeout  <= 1'b0;
                        ack          <= N_REQ'(1) << grant;
                        state        <= RESP;
                    end else if (expired) begin
                        rsp_result   <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        m_abort      <= 1'b1;
                        ack          <= N_REQ'(1) << grant;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == IW'(N_REQ - 1)) ? '0 : grant + IW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier of settable latency.
module tb_mult_arbiter;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req;
    logic [3:0][31:0]  a_v;
    logic [3:0][31:0]  b_v;
    logic [3:0]        ack;
    logic [63:0]       rsp_result;
    logic              rsp_overflow;
    logic              rsp_timeout;
    logic              busy;
    logic              m_start;
    logic [31:0]       m_multiplicand;
    logic [31:0]       m_multiplier;
    logic              m_abort;
    logic              m_done = 1'b0;
    logic [63:0]       m_result = '0;
    logic              m_overflow = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 5;
    int cd    = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.N_REQ(4), .WIDTH(32), .MAX_CYCLES(40)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_a          (a_v),
        .req_b          (b_v),
        .ack            (ack),
        .rsp_result     (rsp_result),
        .rsp_overflow   (rsp_overflow),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .m_start        (m_start),
        .m_multiplicand (m_multiplicand),
        .m_multiplier   (m_multiplier),
        .m_abort        (m_abort),
        .m_done         (m_done),
        .m_result       (m_result),
        .m_overflow     (m_overflow)
    );

    // Multiplier model: done pulses lat cycles after the start cycle; lat=0 never completes.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (!reset) begin
            cd = 0;
        end else if (m_start) begin
            cd         = lat;
            m_result   = {32'b0, m_multiplicand} * {32'b0, m_multiplier};
            m_overflow = |m_result[63:32];
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) m_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] e_ack,
                          input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [63:0] e_res, input logic e_ovf, input logic e_to,
                          input int e_gap, input bit drop_early);
        int starts = 0;
        int gap = 0;
        bit seen = 0;
        bit got = 0;
        logic [31:0] oa = '0;
        logic [31:0] ob = '0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(posedge clk); #1;
            if (m_start) begin
                starts++;
                seen = 1;
                gap  = 0;
                oa   = m_multiplicand;
                ob   = m_multiplier;
                if (drop_early) req = req & ~e_ack;
            end else if (seen) begin
                gap++;
            end
            if (ack != 4'b0) got = 1;
        end
        chk({tag, "_ack"},    64'(ack),          64'(e_ack));
        chk({tag, "_res"},    rsp_result,        e_res);
        chk({tag, "_ovf"},    64'(rsp_overflow), 64'(e_ovf));
        chk({tag, "_to"},     64'(rsp_timeout),  64'(e_to));
        chk({tag, "_abort"},  64'(m_abort),      64'(e_to));
        chk({tag, "_starts"}, 64'(starts),       64'd1);
        chk({tag, "_gap"},    64'(gap),          64'(e_gap));
        chk({tag, "_opa"},    64'(oa),           64'(e_a));
        chk({tag, "_opb"},    64'(ob),           64'(e_b));
        req = req & ~ack;
        @(posedge clk); #1;
        chk({tag, "_ack_off"},   64'(ack),     64'd0);
        chk({tag, "_abort_off"}, 64'(m_abort), 64'd0);
        chk({tag, "_idle"},      64'(busy),    64'd0);
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        a_v   = '0;
        b_v   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   64'(ack),            64'd0);
        chk("rst_res",   rsp_result,          64'd0);
        chk("rst_ovf",   64'(rsp_overflow),   64'd0);
        chk("rst_to",    64'(rsp_timeout),    64'd0);
        chk("rst_busy",  64'(busy),           64'd0);
        chk("rst_start", 64'(m_start),        64'd0);
        chk("rst_abort", 64'(m_abort),        64'd0);
        chk("rst_mcand", 64'(m_multiplicand), 64'd0);
        chk("rst_mplr",  64'(m_multiplier),   64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // All four requesting: served 0,1,2,3, then again from 0.
        a_v[0] = 32'd3;       b_v[0] = 32'd5;
        a_v[1] = 32'd100;     b_v[1] = 32'd200;
        a_v[2] = 32'd7;       b_v[2] = 32'd6;
        a_v[3] = 32'h1_0000;  b_v[3] = 32'h1_0000;
        lat = 5;
        req = 4'b1111;
        run_op("ord0", 4'b0001, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 6, 0);
        run_op("ord1", 4'b0010, 32'd100, 32'd200, 64'd20000, 1'b0, 1'b0, 6, 0);
        run_op("ord2", 4'b0100, 32'd7, 32'd6, 64'd42, 1'b0, 1'b0, 6, 0);
        run_op("ord3", 4'b1000, 32'h1_0000, 32'h1_0000, 64'h1_0000_0000, 1'b1, 1'b0, 6, 0);
        req = 4'b1111;
        run_op("re0", 4'b0001, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 6, 0);
        run_op("re1", 4'b0010, 32'd100, 32'd200, 64'd20000, 1'b0, 1'b0, 6, 0);

        // Pointer at 2: search 2,3,0 picks client 0 before client 1.
        req = 4'b0011;
        run_op("fair0", 4'b0001, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 6, 0);
        run_op("fair1", 4'b0010, 32'd100, 32'd200, 64'd20000, 1'b0, 1'b0, 6, 0);

        lat = 33;
        req = 4'b0100;
        run_op("single", 4'b0100, 32'd7, 32'd6, 64'd42, 1'b0, 1'b0, 34, 0);

        // Overflow; client drops req mid-operation and is still acked.
        lat = 5;
        a_v[3] = 32'hFFFF_FFFF; b_v[3] = 32'd2;
        req = 4'b1000;
        run_op("ovf", 4'b1000, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 1'b1, 1'b0, 6, 1);

        // Timeout: 40 WAIT cycles after LAUNCH, ack on the next.
        lat = 0;
        req = 4'b0010;
        run_op("tmo", 4'b0010, 32'd100, 32'd200, 64'd0, 1'b0, 1'b1, 41, 0);
        lat = 5;
        req = 4'b0001;
        run_op("post", 4'b0001, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 6, 0);

        // Reset mid-WAIT: client 1 is in flight and never completes.
        lat = 0;
        req = 4'b1111;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy",  64'(busy),           64'd0);
        chk("arst_mcand", 64'(m_multiplicand), 64'd0);
        chk("arst_mplr",  64'(m_multiplier),   64'd0);
        chk("arst_res",   rsp_result,          64'd0);
        chk("arst_ack",   64'(ack),            64'd0);
        chk("arst_start", 64'(m_start),        64'd0);
        @(posedge clk); #1;
        lat   = 5;
        reset = 1'b1;
        chk("rel_ack", 64'(ack), 64'd0);
        run_op("rst0", 4'b0001, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0, 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Round-robin scheduler that shares one sequential 32x32 multiplier (start/done handshake, 64-bit result, overflow flag) among N_REQ clients.
- Accepts level requests with operands and launches the multiplier for one client at a time.
- Waits for completion, guarded by a watchdog, then returns the result to that client with a one-cycle ack.
- Sits between client engines and the multiplier instance; owns the multiplier's start and abort inputs.

Parameters:
N_REQ, 4, number of requesting clients (2..8)
WIDTH, 32, operand width; result width is 2*WIDTH
MAX_CYCLES, 40, WAIT-state cycles allowed before a timeout is declared

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req  in  N_REQ  per-client request level; held until that client's ack
req_a  in  N_REQ*WIDTH  packed multiplicands; client i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  packed multipliers, same packing
ack  out  N_REQ  one-hot, one-cycle response pulse
rsp_result  out  2*WIDTH  product for the acked client
rsp_overflow  out  1  multiplier overflow flag, qualified by ack
rsp_timeout  out  1  watchdog expiry, qualified by ack
busy  out  1  high in any state other than IDLE
m_start  out  1  one-cycle start pulse to the multiplier
m_multiplicand  out  WIDTH  latched operand, stable from LAUNCH through WAIT
m_multiplier  out  WIDTH  latched operand, stable from LAUNCH through WAIT
m_abort  out  1  one-cycle pulse to reset the multiplier after a timeout
m_done  in  1  multiplier completion pulse
m_result  in  2*WIDTH  multiplier product, valid with m_done
m_overflow  in  1  multiplier overflow, valid with m_done

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, watchdog=0. All outputs 0, including ack, rsp_*, busy, m_start, m_abort and operand outputs. An in-flight operation is discarded and no ack is issued for it.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req is nonzero, grant the first set bit searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - Latch the grant index and that client's operands into m_multiplicand/m_multiplier, then go to LAUNCH.
  - If req is zero, stay in IDLE.
- LAUNCH (1 cycle): m_start=1; watchdog cleared; go to WAIT. m_done is ignored in this state.
- WAIT: watchdog increments each cycle.
  - On m_done=1: capture m_result and m_overflow; rsp_timeout=0; go to RESP.
  - If the watchdog reaches MAX_CYCLES without m_done: rsp_result=0, rsp_overflow=0, rsp_timeout=1; go to RESP.
  - If m_done and expiry occur in the same cycle, m_done wins.
- RESP (1 cycle):
  - ack[grant]=1.
  - m_abort=1 only if the response is a timeout.
  - rr_ptr = (grant+1) mod N_REQ.
  - Go to IDLE.
- rsp_* are registered and hold their values until the next RESP. They are meaningful only while ack is high.
- Latency: req sampled in IDLE at edge 0 → m_start high in cycle 1 → ack in the cycle after the m_done cycle. Minimum request-to-ack is 3 cycles plus multiplier latency.
- Clients are registered: they drop req at the edge on which they sample ack, so the following IDLE sees it low. A req still high in IDLE is treated as a new request.
- A client dropping req mid-operation does not cancel the operation; ack is still issued.
- m_done outside WAIT is ignored.
- req changes from non-granted clients during LAUNCH/WAIT/RESP have no effect; they are evaluated at the next IDLE.
- Throughput: back-to-back grants pass through one IDLE cycle between RESP and LAUNCH.

Decomposition:
- Package mult_arb_pkg holds:
  - state typedef enum {IDLE, LAUNCH, WAIT, RESP};
  - default constants for WIDTH and MAX_CYCLES;
  - a clog2-based index-width function.
- Sub-module rr_arbiter: combinational. Inputs req and rr_ptr; outputs the grant index and a valid flag.
- The FSM, watchdog and operand/result registers stay in mult_arbiter.

Test Plan:
- Single request: req=4'b0100, a=7, b=6; model asserts done 33 cycles after start → m_start single pulse with operands 7/6; ack=4'b0100, rsp_result=42, rsp_overflow=0, rsp_timeout=0.
- All four req high after reset, each dropped on its ack → grants in order 0,1,2,3. Re-raise all four → order restarts at 0.
- Fairness: after client 1 is served, req=4'b0011 → client 0 is granted (search 2,3,0), then client 1.
- Overflow: a=32'hFFFF_FFFF, b=2; model returns result 64'h1_FFFF_FFFE with overflow=1 → ack with rsp_overflow=1 and that result.
- Timeout: model never asserts done, MAX_CYCLES=40 → ack exactly 40 WAIT cycles after LAUNCH with rsp_timeout=1, rsp_result=0, and a one-cycle m_abort pulse. Next request proceeds normally.
- Reset mid-WAIT: drive reset=0 asynchronously → all outputs 0 immediately, no ack after release. With req=4'b1111 the next grant goes to client 0.
